// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared definitions for the 16-bit request/response memory interface
//
// Purpose : mode encodings shared with the memory responder, bus widths and
//           the burst master state enumeration.
// Ports   : none (package).

package mem_pkg;

   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 16;

   localparam logic MMODE_READ  = 1'b0;
   localparam logic MMODE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_REQ   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - response watchdog cycle counter
//
// Purpose : counts cycles while enabled; clear reloads zero. expire is raised
//           in the cycle whose clock edge is the TIMEOUT-th enabled edge, so
//           the owner can abort on that same edge.
// Ports   : clk, reset (sync, active-high)
//           clear  - reload count with zero (wins over enable)
//           enable - count this cycle
//           expire - enabled count has reached its last allowed value

module mem_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable & ~clear & (count == LAST);

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst-to-single-word initiator for the 16-bit memory interface
//
// Purpose : turns a burst command (start address, beat count, direction) into
//           one request/response handshake per beat, streaming write beats in
//           and read beats out, with a watchdog that aborts a burst when the
//           responder stops answering.
// Ports   : clk, reset (sync, active-high)
//           cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len - burst command
//           wr_data/wr_valid/wr_ready                      - write beat stream
//           rd_data/rd_valid                               - read beat pulses
//           done/err/busy                                  - burst status
//           mem_request/mem_mode/mem_locator/mem_write_data,
//           mem_read_data/mem_response                     - memory side

module mem_burst_master
   import mem_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [MEM_ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic [MEM_DATA_W-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [MEM_DATA_W-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  done,
   output logic                  err,
   output logic                  busy,
   output logic                  mem_request,
   output logic                  mem_mode,
   output logic [MEM_ADDR_W-1:0] mem_locator,
   output logic [MEM_DATA_W-1:0] mem_write_data,
   input  logic [MEM_DATA_W-1:0] mem_read_data,
   input  logic                  mem_response
);

   state_t                  state;
   logic [MEM_ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]        remaining;
   logic                    timed_out;
   logic                    wd_clear;
   logic                    wd_enable;
   logic                    wd_expire;

   // A response still high after a mid-access reset belongs to the aborted
   // access; holding off commands until it falls keeps it from being counted.
   assign cmd_ready = ~reset & (state == ST_IDLE) & ~mem_response;
   assign wr_ready  = (state == ST_WDATA);
   assign busy      = (state != ST_IDLE);

   assign wd_enable = (state == ST_REQ);
   assign wd_clear  = (state != ST_REQ) | mem_response;

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expire (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         addr           <= '0;
         remaining      <= '0;
         timed_out      <= 1'b0;
         rd_data        <= '0;
         rd_valid       <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         mem_request    <= 1'b0;
         mem_mode       <= MMODE_READ;
         mem_locator    <= '0;
         mem_write_data <= '0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  addr      <= cmd_addr;
                  remaining <= cmd_len;
                  mem_mode  <= cmd_write;
                  timed_out <= 1'b0;
                  if (cmd_write == MMODE_WRITE) begin
                     state <= ST_WDATA;
                  end else begin
                     mem_request <= 1'b1;
                     mem_locator <= cmd_addr;
                     state       <= ST_REQ;
                  end
               end
            end
            ST_WDATA: begin
               if (wr_valid) begin
                  mem_write_data <= wr_data;
                  mem_locator    <= addr;
                  mem_request    <= 1'b1;
                  state          <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_response) begin
                  if (mem_mode == MMODE_READ) begin
                     rd_data  <= mem_read_data;
                     rd_valid <= 1'b1;
                  end
                  if (remaining == '0) begin
                     mem_request <= 1'b0;
                     state       <= ST_DONE;
                  end else begin
                     remaining <= remaining - 1'b1;
                     addr      <= addr + 1'b1;
                     if (mem_mode == MMODE_READ) begin
                        // Request stays high: the responder is in its clear
                        // phase, so the new locator settles before next service.
                        mem_locator <= addr + 1'b1;
                     end else begin
                        mem_request <= 1'b0;
                        state       <= ST_WDATA;
                     end
                  end
               end else if (wd_expire) begin
                  mem_request <= 1'b0;
                  timed_out   <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               err       <= timed_out;
               timed_out <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - self-checking bench for mem_burst_master

module tb_mem_burst_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [15:0] wr_data;
   logic        wr_valid;
   logic        cmd_ready, wr_ready;
   logic [15:0] rd_data;
   logic        rd_valid, done, err, busy;
   logic        mem_request, mem_mode;
   logic [15:0] mem_locator, mem_write_data;
   logic [15:0] mem_read_data = 16'h0;
   logic        mem_response  = 1'b0;

   mem_burst_master #(.LEN_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
      .mem_request(mem_request), .mem_mode(mem_mode), .mem_locator(mem_locator),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_response(mem_response)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- memory responder (environment) ----------------
   logic [15:0] mem [0:65535];
   logic        dead = 1'b0;
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;
   logic [15:0] wl_addr[$];
   logic [15:0] wl_data[$];

   always @(negedge clk) begin
      if (pl_en) mem[pl_addr] = pl_data;
      if (mem_response) begin
         mem_response = 1'b0;
      end else if (mem_request && !dead) begin
         if (mem_mode) begin
            mem[mem_locator] = mem_write_data;
            wl_addr.push_back(mem_locator);
            wl_data.push_back(mem_write_data);
         end
         mem_read_data = mem[mem_locator];
         mem_response  = 1'b1;
      end
   end

   // ---------------- behavioural model: expected events by cycle ----------------
   bit          exp_rdv[int];
   logic [15:0] exp_rdd[int];
   bit          exp_done[int];
   bit          exp_err[int];
   bit          chk_on  = 1'b0;
   bit          wr_mode = 1'b0;

   // Read of n beats accepted in cycle c: beat i in cycle c+1+2i, done in c+2n.
   task automatic plan_read(input int c, input logic [15:0] a, input int n);
      logic [15:0] p;
      for (int i = 0; i < n; i++) begin
         p = a + 16'(i);
         exp_rdv[c + 1 + 2*i] = 1'b1;
         exp_rdd[c + 1 + 2*i] = mem[p];
      end
      exp_done[c + 2*n] = 1'b1;
   endtask

   // Dead responder: request held TIMEOUT cycles, done+err one cycle after drop.
   task automatic plan_timeout(input int c);
      exp_done[c + TIMEOUT + 1] = 1'b1;
      exp_err[c + TIMEOUT + 1]  = 1'b1;
   endtask

   // ---------------- compare process ----------------
   logic [15:0] obs_d[$];
   int          obs_c[$];
   int          done_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (rd_valid) begin
         obs_d.push_back(rd_data);
         obs_c.push_back(cyc);
      end
      if (done) done_cnt++;
      if (chk_on) begin
         chk("rd_valid", rd_valid, exp_rdv.exists(cyc));
         if (exp_rdv.exists(cyc)) chk("rd_data", rd_data, exp_rdd[cyc]);
         chk("err", err, exp_err.exists(cyc));
         if (!wr_mode) chk("done", done, exp_done.exists(cyc));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_addr = a; pl_data = d; pl_en = 1'b1;
      @(negedge clk); #1;
      pl_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] l, output int c);
      int k;
      k = 0;
      while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
      chk("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      @(posedge clk); #1;
      c = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic send_wr(input logic [15:0] d, input int gap);
      int k;
      k = 0;
      while (!wr_ready && k < 50) begin @(posedge clk); #1; k++; end
      chk("wr_ready_wait", wr_ready, 1);
      for (int g = 0; g < gap; g++) begin
         chk("gap_req_low", mem_request, 0);
         chk("gap_wr_ready", wr_ready, 1);
         @(posedge clk); #1;
      end
      wr_valid = 1'b1; wr_data = d;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int reqcnt, output int dcyc);
      reqcnt = 0;
      dcyc   = -1;
      for (int k = 0; k < bound; k++) begin
         if (mem_request) reqcnt++;
         if (done) begin
            dcyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (dcyc < 0) chk("done_seen", done, 1);
   endtask

   // ---------------- main sequence ----------------
   int c, rq, dc, ob, wb, db;
   logic [15:0] burst_vals [4];

   initial begin
      burst_vals[0] = 16'h0001; burst_vals[1] = 16'h0002;
      burst_vals[2] = 16'h0003; burst_vals[3] = 16'h0004;
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
      cmd_len = 8'h0; wr_data = 16'h0; wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_request", mem_request, 0);
      chk("rst_mem_locator", mem_locator, 0);
      chk("rst_mem_write_data", mem_write_data, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_flags", {rd_valid, done, err, mem_mode}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_on = 1'b1;

      // single read
      preload(16'h0010, 16'hBEEF);
      ob = obs_d.size(); db = done_cnt;
      issue(1'b0, 16'h0010, 8'd0, c);
      chk("single_busy", busy, 1);
      plan_read(c, 16'h0010, 1);
      wait_done(40, rq, dc);
      @(posedge clk); #1;
      chk("single_req_cycles", rq, 1);
      chk("single_beats", obs_d.size() - ob, 1);
      if (obs_d.size() > ob) begin
         chk("single_data_lit", obs_d[ob], 16'hBEEF);
         chk("single_rd_latency", obs_c[ob] - c, 1);
      end
      chk("single_done_latency", dc - c, 2);
      chk("single_done_count", done_cnt - db, 1);

      // read burst
      for (int i = 0; i < 4; i++) preload(16'h0100 + 16'(i), burst_vals[i]);
      ob = obs_d.size(); db = done_cnt;
      issue(1'b0, 16'h0100, 8'd3, c);
      plan_read(c, 16'h0100, 4);
      wait_done(60, rq, dc);
      @(posedge clk); #1;
      chk("burst_beats", obs_d.size() - ob, 4);
      if (obs_d.size() >= ob + 4) begin
         for (int i = 0; i < 4; i++) chk("burst_data_lit", obs_d[ob+i], 32'(i + 1));
         for (int i = 1; i < 4; i++) chk("burst_spacing", obs_c[ob+i] - obs_c[ob+i-1], 2);
      end
      chk("burst_done_latency", dc - c, 8);
      chk("burst_done_count", done_cnt - db, 1);

      // write burst with a gap before the second beat
      wr_mode = 1'b1;
      wb = wl_addr.size(); db = done_cnt;
      issue(1'b1, 16'h0200, 8'd2, c);
      send_wr(16'h000A, 0);
      send_wr(16'h000B, 5);
      send_wr(16'h000C, 0);
      wait_done(60, rq, dc);
      @(posedge clk); #1;
      chk("wr_count", wl_addr.size() - wb, 3);
      if (wl_addr.size() >= wb + 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("wr_addr", wl_addr[wb+i], 32'h0200 + 32'(i));
            chk("wr_data", wl_data[wb+i], 32'h000A + 32'(i));
         end
      end
      chk("wr_mem_0200", mem[16'h0200], 16'h000A);
      chk("wr_mem_0202", mem[16'h0202], 16'h000C);
      chk("wr_done_count", done_cnt - db, 1);

      // write burst wrapping past 0xFFFF
      wb = wl_addr.size();
      issue(1'b1, 16'hFFFF, 8'd1, c);
      send_wr(16'h1111, 0);
      send_wr(16'h2222, 0);
      wait_done(60, rq, dc);
      @(posedge clk); #1;
      wr_mode = 1'b0;
      chk("wrap_count", wl_addr.size() - wb, 2);
      chk("wrap_mem_ffff", mem[16'hFFFF], 16'h1111);
      chk("wrap_mem_0000", mem[16'h0000], 16'h2222);

      // timeout on a dead responder (remaining beats discarded)
      dead = 1'b1;
      db = done_cnt; ob = obs_d.size();
      issue(1'b0, 16'h0040, 8'd2, c);
      plan_timeout(c);
      wait_done(60, rq, dc);
      chk("to_req_cycles", rq, 16);
      chk("to_done_latency", dc - c, 17);
      chk("to_err_with_done", err, 1);
      chk("to_cmd_ready_done_cycle", cmd_ready, 1);
      @(posedge clk); #1;
      chk("to_cmd_ready_next", cmd_ready, 1);
      chk("to_busy_next", busy, 0);
      chk("to_done_count", done_cnt - db, 1);
      chk("to_no_read_beats", obs_d.size() - ob, 0);
      dead = 1'b0;

      // reset while a response is high
      chk_on = 1'b0;
      issue(1'b0, 16'h0100, 8'd3, c);
      for (int k = 0; k < 10 && !mem_response; k++) begin @(negedge clk); #1; end
      chk("rst_resp_seen", mem_response, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_mem_request", mem_request, 0);
      chk("mid_outputs", {rd_valid, done, err, busy, wr_ready, mem_mode}, 0);
      chk("mid_locator", mem_locator, 0);
      chk("mid_rd_data", rd_data, 0);
      chk("mid_resp_still_high", mem_response, 1);
      reset = 1'b0;
      #1;
      chk("mid_cmd_ready_held", cmd_ready, 0);
      @(negedge clk); #1;
      chk("mid_cmd_ready_after", cmd_ready, 1);
      @(posedge clk); #1;
      chk("mid_no_done", done, 0);
      chk_on = 1'b1;
      preload(16'h0300, 16'h5A5A);
      ob = obs_d.size();
      issue(1'b0, 16'h0300, 8'd0, c);
      plan_read(c, 16'h0300, 1);
      wait_done(40, rq, dc);
      @(posedge clk); #1;
      chk("post_rst_beats", obs_d.size() - ob, 1);
      if (obs_d.size() > ob) chk("post_rst_data_lit", obs_d[ob], 16'h5A5A);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
